// File: rtl/adc_stream_arbiter.sv
// Round-robin arbiter that frames one channel's stream per grant: a header beat
// followed by BURST_LEN data beats onto the shared 128-bit capture path.
module adc_stream_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int BURST_LEN    = 16,
  localparam int CW          = $clog2(NUM_CHANNELS)
) (
  input  logic                        pl_clk,
  input  logic                        rst,
  input  logic [NUM_CHANNELS-1:0]     chan_enable,
  input  logic [NUM_CHANNELS*128-1:0] s_axis_tdata,
  input  logic [NUM_CHANNELS-1:0]     s_axis_tvalid,
  output logic [NUM_CHANNELS-1:0]     s_axis_tready,
  output logic [127:0]                m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [CW-1:0]               active_chan,
  output logic                        busy,
  output logic [31:0]                 seq_num
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_DATA
  } state_t;

  localparam logic [15:0] HDR_MAGIC = 16'hADC0;
  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);
  localparam logic [CW-1:0] MAX_CHAN = CW'(NUM_CHANNELS - 1);

  state_t        state;
  logic [CW-1:0] rr_ptr;
  logic [15:0]   beat_cnt;
  logic [127:0]  header_q;

  logic [NUM_CHANNELS-1:0] req;
  logic                    grant_found;
  logic [CW-1:0]           grant_idx;
  logic [127:0]            chan_data [NUM_CHANNELS];
  logic [127:0]            granted_tdata;
  logic                    granted_tvalid;
  logic                    granted_hs;
  logic                    last_beat;
  logic [CW-1:0]           next_ptr;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_unpack
    assign chan_data[c] = s_axis_tdata[128*c +: 128];
  end

  assign req            = s_axis_tvalid & chan_enable;
  assign granted_tdata  = chan_data[active_chan];
  assign granted_tvalid = s_axis_tvalid[active_chan];
  assign granted_hs     = (state == S_DATA) && granted_tvalid && m_axis_tready;
  assign last_beat      = (beat_cnt == LAST_BEAT);
  assign next_ptr       = (active_chan == MAX_CHAN) ? '0 : active_chan + 1'b1;
  assign busy           = (state != S_IDLE);

  // Search starts at rr_ptr (one past the last grant) and wraps.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CW'(idx);
      end
    end
  end

  always_ff @(posedge pl_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      active_chan <= '0;
      beat_cnt    <= '0;
      seq_num     <= '0;
      header_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            active_chan <= grant_idx;
            header_q    <= {HDR_MAGIC, 8'(grant_idx), 16'(BURST_LEN), seq_num, 56'd0};
            state       <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (m_axis_tready) begin
            seq_num  <= seq_num + 32'd1;
            beat_cnt <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (granted_hs) begin
            if (last_beat) begin
              rr_ptr <= next_ptr;
              state  <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // DATA is a straight pass-through; the only ready path is downstream ready
  // to the granted source.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (state)
      S_HEADER: begin
        m_axis_tdata  = header_q;
        m_axis_tvalid = 1'b1;
      end
      S_DATA: begin
        m_axis_tdata               = granted_tdata;
        m_axis_tvalid              = granted_tvalid;
        m_axis_tlast               = last_beat;
        s_axis_tready[active_chan] = m_axis_tready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_adc_stream_arbiter.sv
// Randomized bench for adc_stream_arbiter checked against a packet-level model
// of grants, headers and per-channel data sequences.
module tb_adc_stream_arbiter;

  localparam int N  = 4;
  localparam int BL = 4;
  localparam int CW = $clog2(N);

  logic               pl_clk = 1'b0;
  logic               rst;
  logic [N-1:0]       chan_enable;
  logic [N*128-1:0]   s_axis_tdata;
  logic [N-1:0]       s_axis_tvalid;
  logic [N-1:0]       s_axis_tready;
  logic [127:0]       m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;
  logic [CW-1:0]      active_chan;
  logic               busy;
  logic [31:0]        seq_num;

  adc_stream_arbiter #(.NUM_CHANNELS(N), .BURST_LEN(BL)) dut (
    .pl_clk       (pl_clk),
    .rst          (rst),
    .chan_enable  (chan_enable),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .active_chan  (active_chan),
    .busy         (busy),
    .seq_num      (seq_num)
  );

  always #5 pl_clk = ~pl_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Each source emits a numbered sequence so every data beat is identifiable.
  function automatic logic [127:0] mk_data(input int ch, input int cnt);
    return {32'(ch), 32'hDA7A_0000, 32'(cnt), ~32'(cnt)};
  endfunction

  int src_cnt [N];

  always_comb begin
    s_axis_tdata = '0;
    for (int c = 0; c < N; c++) s_axis_tdata[128*c +: 128] = mk_data(c, src_cnt[c]);
  end

  // Packet-level reference model.
  typedef enum {M_IDLE, M_HDR, M_DATA} mphase_t;
  mphase_t     ph;
  int          g;
  int          ptr;
  int          beat;
  logic [31:0] mseq;
  int          mcnt [N];
  int          ids [$];

  function automatic int rr_pick(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) if (r[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  task automatic step();
    logic [N-1:0] hs;
    logic         was_rst;
    hs      = '0;
    was_rst = rst;
    @(negedge pl_clk);
    check("seq_num", seq_num, mseq);
    check("busy", busy, ph != M_IDLE);
    case (ph)
      M_IDLE: begin
        check("idle_tvalid", m_axis_tvalid, 0);
        check("idle_sready", s_axis_tready, 0);
        if (!rst && (s_axis_tvalid & chan_enable) != 0) begin
          g  = rr_pick(s_axis_tvalid & chan_enable, ptr);
          ph = M_HDR;
        end
      end
      M_HDR: begin
        check("hdr_tvalid", m_axis_tvalid, 1);
        check("hdr_tlast", m_axis_tlast, 0);
        check("hdr_sready", s_axis_tready, 0);
        check("hdr_chan", active_chan, g);
        check("hdr_data", m_axis_tdata, {16'hADC0, 8'(g), 16'(BL), mseq, 56'd0});
        if (m_axis_tready && !rst) begin
          ids.push_back(int'(m_axis_tdata[111:104]));
          mseq = mseq + 1;
          beat = 0;
          ph   = M_DATA;
        end
      end
      default: begin
        check("data_chan", active_chan, g);
        check("data_tvalid", m_axis_tvalid, s_axis_tvalid[g]);
        check("data_sready", s_axis_tready, N'(m_axis_tready) << g);
        check("data_tlast", m_axis_tlast, beat == BL - 1);
        if (s_axis_tvalid[g] && m_axis_tready) begin
          check("data_beat", m_axis_tdata, mk_data(g, mcnt[g]));
          mcnt[g]++;
          hs[g] = 1'b1;
          beat++;
          if (beat == BL) begin
            ph  = M_IDLE;
            ptr = (g + 1) % N;
          end
        end
      end
    endcase
    if (rst) begin
      ph   = M_IDLE;
      ptr  = 0;
      mseq = '0;
      beat = 0;
    end
    @(posedge pl_clk);
    #1;
    for (int c = 0; c < N; c++) if (hs[c]) src_cnt[c]++;
    if (rst && !was_rst) begin
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_sready", s_axis_tready, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_seq", seq_num, 0);
      check("rst_chan", active_chan, 0);
      check("rst_busy", busy, 0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_data(input string tag, input int want_beat, input int want_chan);
    int k;
    for (k = 0; k < 60; k++) begin
      if (ph == M_DATA && beat == want_beat && (want_chan < 0 || g == want_chan)) break;
      step();
    end
    check(tag, k < 60, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 60 && ph != M_IDLE; k++) step();
    check(tag, ph == M_IDLE, 1);
  endtask

  initial begin
    rst           = 1'b1;
    chan_enable   = '0;
    s_axis_tvalid = '0;
    m_axis_tready = 1'b0;
    for (int c = 0; c < N; c++) begin
      src_cnt[c] = 0;
      mcnt[c]    = 0;
    end
    ph   = M_IDLE;
    ptr  = 0;
    beat = 0;
    mseq = '0;
    g    = 0;
    repeat (2) @(posedge pl_clk);
    #1;
    check("init_tvalid", m_axis_tvalid, 0);
    check("init_sready", s_axis_tready, 0);
    check("init_tdata", m_axis_tdata, 0);
    check("init_seq", seq_num, 0);
    check("init_busy", busy, 0);
    check("init_chan", active_chan, 0);
    rst = 1'b0;

    // Single enabled channel, consecutive packets carry seq 0 then 1.
    chan_enable   = 4'b0100;
    s_axis_tvalid = '1;
    m_axis_tready = 1'b1;
    run(2 * (BL + 2) + 2);
    check("single_n", ids.size() >= 2, 1);
    for (int i = 0; i < ids.size() && i < 2; i++) check("single_id", ids[i], 2);

    // All channels requesting: strict rotation from channel 0.
    do_reset();
    ids.delete();
    chan_enable = '1;
    run(5 * (BL + 2) + 2);
    check("rr_n", ids.size() >= 5, 1);
    for (int i = 0; i < ids.size() && i < 5; i++) check("rr_id", ids[i], i % N);

    // Header held under backpressure.
    do_reset();
    chan_enable   = 4'b0001;
    m_axis_tready = 1'b0;
    run(2);
    check("bp_in_hdr", ph == M_HDR, 1);
    run(5);
    m_axis_tready = 1'b1;
    run(BL + 4);

    // Granted source stalls while another channel requests.
    do_reset();
    ids.delete();
    chan_enable = 4'b0110;
    wait_data("stall_reach", 1, 1);
    s_axis_tvalid[1] = 1'b0;
    run(3);
    check("stall_chan", active_chan, 1);
    s_axis_tvalid[1] = 1'b1;
    wait_idle("stall_done");
    check("stall_id", ids.size() > 0 && ids[0] == 1, 1);

    // Enable mask alternates between channels 1 and 3.
    do_reset();
    ids.delete();
    chan_enable = 4'b1010;
    run(4 * (BL + 2) + 2);
    check("mask_n", ids.size() >= 4, 1);
    for (int i = 0; i < ids.size() && i < 4; i++) check("mask_id", ids[i], (i % 2) ? 3 : 1);
    wait_data("mask_reach", 1, 1);
    chan_enable = 4'b1000;
    wait_idle("mask_done");
    ids.delete();
    run(2 * (BL + 2) + 2);
    check("mask3_n", ids.size() >= 2, 1);
    for (int i = 0; i < ids.size(); i++) check("mask3_id", ids[i], 3);

    // Reset in the middle of a packet, then channel 0 wins.
    chan_enable = '1;
    wait_data("mid_reach", 2, -1);
    do_reset();
    ids.delete();
    run(BL + 4);
    check("post_rst_id", ids.size() > 0 && ids[0] == 0, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      chan_enable   = N'($urandom);
      for (int c = 0; c < N; c++) s_axis_tvalid[c] = ($urandom_range(0, 3) != 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_stream_arbiter.md
Name: adc_stream_arbiter

Overview:
- Round-robin arbiter in the pl_clk domain. It shares the single 128-bit PL-to-PS capture path between several adc_ctrl channel streams.
- Each grant emits one framed packet: one 128-bit header beat, then exactly BURST_LEN data beats from the granted channel. The last data beat carries tlast.
- Its output feeds the 128-to-32 width converter and async FIFO toward the PS.

Parameters:
NUM_CHANNELS, 4, number of requesting ADC streams (2..8)
BURST_LEN, 16, data beats per packet after the header (1..65535)

Ports:
pl_clk  input  1  fabric clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
chan_enable  input  NUM_CHANNELS  per-channel arbitration enable
s_axis_tdata  input  NUM_CHANNELS*128  channel data; channel i at bits [128*i+127:128*i]
s_axis_tvalid  input  NUM_CHANNELS  per-channel valid
s_axis_tready  output  NUM_CHANNELS  per-channel ready
m_axis_tdata  output  128  packet stream to the width converter
m_axis_tvalid  output  1  packet valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  high on the final data beat of a packet
active_chan  output  $clog2(NUM_CHANNELS)  currently or last granted channel
busy  output  1  high in HEADER or DATA
seq_num  output  32  count of headers accepted since reset

Behaviour:
- Reset (rst high at a pl_clk edge):
  - state=IDLE; all s_axis_tready=0; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - active_chan=0, busy=0, seq_num=0, beat counter=0.
  - Round-robin pointer set so channel 0 has highest priority.
  - Reset mid-packet aborts the packet immediately; no tlast is emitted for it.
- Request vector: req = s_axis_tvalid & chan_enable, evaluated only in IDLE. chan_enable is ignored once a grant is made; a channel disabled mid-packet still completes its packet.
- State machine IDLE / HEADER / DATA:
  - IDLE:
    - Outputs: m_axis_tvalid=0, all s_axis_tready=0.
    - If req is nonzero, grant the first set bit searching from (last grant + 1) mod NUM_CHANNELS, wrapping. Register it into active_chan.
    - Build the header register. Next state is HEADER.
    - Latency: one idle cycle from req high to header valid.
  - HEADER:
    - Outputs: m_axis_tvalid=1, m_axis_tlast=0, header driven from a register, all s_axis_tready=0.
    - Header is held stable until m_axis_tready=1.
    - On handshake: seq_num increments (wraps 2^32-1 to 0), beat counter cleared, next state DATA.
  - DATA:
    - Combinational pass-through of the granted channel: m_axis_tdata = granted tdata, m_axis_tvalid = granted tvalid, s_axis_tready[grant] = m_axis_tready. All other s_axis_tready=0.
    - m_axis_tlast = (beat counter == BURST_LEN-1).
    - Counter increments only on a granted handshake (tvalid & tready).
    - On the handshake of the final beat: next state IDLE, pointer = grant + 1.
    - A source tvalid gap stalls the packet indefinitely. There is no timeout and no re-arbitration.
- Header format:
  - [127:112] = 16'hADC0
  - [111:104] = channel id, zero-extended
  - [103:88] = BURST_LEN
  - [87:56] = seq_num value before the increment
  - [55:0] = 0
- Fairness: a channel that has just been served is lowest priority at the next arbitration. With all channels requesting continuously, grants are strictly 0,1,...,N-1,0,...
- BURST_LEN=1: the single data beat carries tlast.
- busy=1 in HEADER and DATA. active_chan holds its value in IDLE.
- No combinational path from m_axis_tready to m_axis_tvalid. The only ready paths are tready to s_axis_tready[grant] in DATA.

Test Plan:
- Single channel: ch2 enabled, continuously valid, BURST_LEN=4, tready=1. Required: header 0xADC0 / id 2 / len 4 / seq 0, then 4 beats, tlast on the 4th. Next packet header has seq 1.
- All 4 channels valid and enabled, tready=1. Required: headers carry ids 0,1,2,3,0 in order. Each packet is exactly 1+BURST_LEN beats with no interleaving.
- Header backpressure: tready=0 for 5 cycles during HEADER. Required: tvalid stays 1, header data unchanged, seq_num unchanged until the handshake, s_axis_tready all 0.
- Source stall: granted channel drops tvalid for 3 beats mid-packet while another channel requests. Required: m_axis_tvalid=0 during the gap, no grant change, the packet resumes and completes with correct beat count and tlast.
- Enable mask: chan_enable=4'b1010, all valid. Required: grants alternate 1,3,1,3. Clearing bit 1 mid-packet still completes that packet.
- Reset mid-DATA at beat 2. Required: next cycle m_axis_tvalid=0, s_axis_tready=0, seq_num=0. The next grant goes to ch0 if it is requesting.
